// File: rtl/src_ctrl_pkg.sv
// Shared constants and types for the Mini SRC hardwired control unit:
// opcodes, the sequencer state set and the decoded strobe bundle.
package src_ctrl_pkg;

  localparam logic [4:0] LD   = 5'b00000;
  localparam logic [4:0] LDI  = 5'b00001;
  localparam logic [4:0] ST   = 5'b00010;
  localparam logic [4:0] ADD  = 5'b00011;
  localparam logic [4:0] SUB  = 5'b00100;
  localparam logic [4:0] AND  = 5'b01001;
  localparam logic [4:0] OR   = 5'b01010;
  localparam logic [4:0] ADDI = 5'b01011;
  localparam logic [4:0] NOP  = 5'b11001;
  localparam logic [4:0] HALT = 5'b11010;

  localparam logic [4:0] OP_ADD = 5'b00011;

  typedef enum logic [3:0] {
    RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALTED
  } state_t;

  // last marks the final execute state of an instruction; halt marks T3 of halt.
  typedef struct packed {
    logic pout, pen, inc_pc, mar_en, mdr_en, mdr_out, ir_en, y_en, zlo_en;
    logic zlo_out, c_out, read, write, gra, grb, grc, r_in, r_out, ba_out;
    logic [4:0] alu;
    logic illegal;
    logic last;
    logic halt;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decode.sv
// Purely combinational Moore decode: {state, opcode} to the DataPath
// strobe bundle plus instruction-boundary flags for the sequencer.
module ctrl_decode
  import src_ctrl_pkg::*;
#(
  parameter logic [4:0] EA_ALU = OP_ADD
) (
  input  state_t     state,
  input  logic [4:0] opcode,
  output ctrl_t      ctrl
);

  logic is_r, is_ld, is_st, is_ldi, is_addi, is_nop, is_halt, is_known;

  assign is_r     = (opcode == ADD) || (opcode == SUB) || (opcode == AND) || (opcode == OR);
  assign is_ld    = (opcode == LD);
  assign is_st    = (opcode == ST);
  assign is_ldi   = (opcode == LDI);
  assign is_addi  = (opcode == ADDI);
  assign is_nop   = (opcode == NOP);
  assign is_halt  = (opcode == HALT);
  assign is_known = is_r || is_ld || is_st || is_ldi || is_addi || is_nop || is_halt;

  always_comb begin
    ctrl = '0;
    case (state)
      T0: begin
        ctrl.pout   = 1'b1;
        ctrl.mar_en = 1'b1;
        ctrl.inc_pc = 1'b1;
        ctrl.zlo_en = 1'b1;
      end
      T1: begin
        ctrl.zlo_out = 1'b1;
        ctrl.pen     = 1'b1;
        ctrl.read    = 1'b1;
        ctrl.mdr_en  = 1'b1;
      end
      T2: begin
        ctrl.mdr_out = 1'b1;
        ctrl.ir_en   = 1'b1;
      end
      T3: begin
        // ld/st/ldi use base-or-zero (BAout); R-format and addi read the register
        if (is_r || is_addi) begin
          ctrl.grb   = 1'b1;
          ctrl.r_out = 1'b1;
          ctrl.y_en  = 1'b1;
        end else if (is_ldi || is_ld || is_st) begin
          ctrl.grb    = 1'b1;
          ctrl.ba_out = 1'b1;
          ctrl.y_en   = 1'b1;
        end
        ctrl.illegal = !is_known;
        ctrl.halt    = is_halt;
        ctrl.last    = is_nop || !is_known;
      end
      T4: begin
        ctrl.zlo_en = 1'b1;
        if (is_r) begin
          ctrl.grc   = 1'b1;
          ctrl.r_out = 1'b1;
          ctrl.alu   = opcode;
        end else begin
          ctrl.c_out = 1'b1;
          ctrl.alu   = EA_ALU;
        end
      end
      T5: begin
        ctrl.zlo_out = 1'b1;
        if (is_ld || is_st) begin
          ctrl.mar_en = 1'b1;
        end else begin
          ctrl.gra  = 1'b1;
          ctrl.r_in = 1'b1;
          ctrl.last = 1'b1;
        end
      end
      T6: begin
        ctrl.mdr_en = 1'b1;
        if (is_ld) begin
          ctrl.read = 1'b1;
        end else begin
          ctrl.gra   = 1'b1;
          ctrl.r_out = 1'b1;
        end
      end
      T7: begin
        ctrl.last = 1'b1;
        if (is_ld) begin
          ctrl.mdr_out = 1'b1;
          ctrl.gra     = 1'b1;
          ctrl.r_in    = 1'b1;
        end else begin
          ctrl.write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Mini SRC hardwired control sequencer: state register, retired-instruction
// counter and halt handling; strobes come from ctrl_decode.
module control_sequencer #(
  parameter int         CNT_W  = 16,
  parameter logic [4:0] OP_ADD = 5'b00011
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [31:0]          ir,
  input  logic                 stop,
  output logic                 Pout,
  output logic                 Pen,
  output logic                 IncPC,
  output logic                 MARen,
  output logic                 MDRen,
  output logic                 MDROut,
  output logic                 IRen,
  output logic                 Yen,
  output logic                 ZLOen,
  output logic                 ZLOout,
  output logic                 Cout,
  output logic                 Read,
  output logic                 Write,
  output logic                 Gra,
  output logic                 Grb,
  output logic                 Grc,
  output logic                 Rin,
  output logic                 Rout,
  output logic                 BAout,
  output logic [4:0]           alu_control,
  output logic                 run,
  output logic                 illegal_op,
  output logic [CNT_W-1:0]     instr_count,
  output src_ctrl_pkg::state_t dbg_state
);

  src_ctrl_pkg::state_t state, next;
  src_ctrl_pkg::ctrl_t  ctrl;
  logic [CNT_W-1:0]     count;
  logic                 boundary;
  logic                 unused_ir;

  assign unused_ir = ^ir[26:0];

  ctrl_decode #(.EA_ALU(OP_ADD)) u_decode (
    .state  (state),
    .opcode (ir[31:27]),
    .ctrl   (ctrl)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= src_ctrl_pkg::RESET;
      count <= '0;
    end else begin
      state <= next;
      if (boundary) count <= count + CNT_W'(1);
    end
  end

  always_comb begin
    next     = state;
    boundary = ctrl.last;
    case (state)
      src_ctrl_pkg::RESET:  next = src_ctrl_pkg::T0;
      src_ctrl_pkg::T0:     next = src_ctrl_pkg::T1;
      src_ctrl_pkg::T1:     next = src_ctrl_pkg::T2;
      src_ctrl_pkg::T2:     next = src_ctrl_pkg::T3;
      src_ctrl_pkg::T3:     next = ctrl.halt ? src_ctrl_pkg::HALTED : src_ctrl_pkg::T4;
      src_ctrl_pkg::T4:     next = src_ctrl_pkg::T5;
      src_ctrl_pkg::T5:     next = src_ctrl_pkg::T6;
      src_ctrl_pkg::T6:     next = src_ctrl_pkg::T7;
      src_ctrl_pkg::T7:     next = src_ctrl_pkg::T0;
      src_ctrl_pkg::HALTED: next = src_ctrl_pkg::HALTED;
      default:              next = src_ctrl_pkg::RESET;
    endcase
    // stop only takes effect at an instruction boundary
    if (ctrl.last) next = stop ? src_ctrl_pkg::HALTED : src_ctrl_pkg::T0;
  end

  assign run         = (state != src_ctrl_pkg::RESET) && (state != src_ctrl_pkg::HALTED);
  assign instr_count = count;
  assign dbg_state   = state;

  assign Pout        = ctrl.pout;
  assign Pen         = ctrl.pen;
  assign IncPC       = ctrl.inc_pc;
  assign MARen       = ctrl.mar_en;
  assign MDRen       = ctrl.mdr_en;
  assign MDROut      = ctrl.mdr_out;
  assign IRen        = ctrl.ir_en;
  assign Yen         = ctrl.y_en;
  assign ZLOen       = ctrl.zlo_en;
  assign ZLOout      = ctrl.zlo_out;
  assign Cout        = ctrl.c_out;
  assign Read        = ctrl.read;
  assign Write       = ctrl.write;
  assign Gra         = ctrl.gra;
  assign Grb         = ctrl.grb;
  assign Grc         = ctrl.grc;
  assign Rin         = ctrl.r_in;
  assign Rout        = ctrl.r_out;
  assign BAout       = ctrl.ba_out;
  assign alu_control = ctrl.alu;
  assign illegal_op  = ctrl.illegal;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: per-cycle strobe vectors against
// a cycle-indexed instruction model, plus halt, stop, reset and wrap scenarios.
module tb_control_sequencer;

  localparam logic [4:0] O_LD   = 5'b00000;
  localparam logic [4:0] O_LDI  = 5'b00001;
  localparam logic [4:0] O_ST   = 5'b00010;
  localparam logic [4:0] O_ADD  = 5'b00011;
  localparam logic [4:0] O_SUB  = 5'b00100;
  localparam logic [4:0] O_AND  = 5'b01001;
  localparam logic [4:0] O_OR   = 5'b01010;
  localparam logic [4:0] O_ADDI = 5'b01011;
  localparam logic [4:0] O_NOP  = 5'b11001;
  localparam logic [4:0] O_HALT = 5'b11010;

  // Bit positions of the observed vector.
  localparam int B_POUT = 25, B_PEN = 24, B_INC = 23, B_MAR = 22, B_MDREN = 21;
  localparam int B_MDROUT = 20, B_IREN = 19, B_YEN = 18, B_ZEN = 17, B_ZOUT = 16;
  localparam int B_COUT = 15, B_READ = 14, B_WRITE = 13, B_GRA = 12, B_GRB = 11;
  localparam int B_GRC = 10, B_RIN = 9, B_ROUT = 8, B_BA = 7, B_ILL = 1, B_RUN = 0;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] ir = '0;

  logic Pout, Pen, IncPC, MARen, MDRen, MDROut, IRen, Yen, ZLOen, ZLOout, Cout;
  logic Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, run, illegal_op;
  logic [4:0]  alu_control;
  logic [15:0] instr_count;
  logic [3:0]  dbg_state;

  logic w_Pout, w_Pen, w_IncPC, w_MARen, w_MDRen, w_MDROut, w_IRen, w_Yen, w_ZLOen;
  logic w_ZLOout, w_Cout, w_Read, w_Write, w_Gra, w_Grb, w_Grc, w_Rin, w_Rout, w_BAout;
  logic w_run, w_illegal_op;
  logic [4:0] w_alu_control;
  logic [2:0] w_instr_count;
  logic [3:0] w_dbg_state;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] model_count = '0;

  control_sequencer dut (
    .clk(clk), .clr(clr), .ir(ir), .stop(stop),
    .Pout(Pout), .Pen(Pen), .IncPC(IncPC), .MARen(MARen), .MDRen(MDRen),
    .MDROut(MDROut), .IRen(IRen), .Yen(Yen), .ZLOen(ZLOen), .ZLOout(ZLOout),
    .Cout(Cout), .Read(Read), .Write(Write), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .Rout(Rout), .BAout(BAout), .alu_control(alu_control), .run(run),
    .illegal_op(illegal_op), .instr_count(instr_count), .dbg_state(dbg_state)
  );

  // Narrow-counter instance to reach the counter wrap within a short run.
  control_sequencer #(.CNT_W(3)) dut_w (
    .clk(clk), .clr(clr), .ir(ir), .stop(stop),
    .Pout(w_Pout), .Pen(w_Pen), .IncPC(w_IncPC), .MARen(w_MARen), .MDRen(w_MDRen),
    .MDROut(w_MDROut), .IRen(w_IRen), .Yen(w_Yen), .ZLOen(w_ZLOen), .ZLOout(w_ZLOout),
    .Cout(w_Cout), .Read(w_Read), .Write(w_Write), .Gra(w_Gra), .Grb(w_Grb), .Grc(w_Grc),
    .Rin(w_Rin), .Rout(w_Rout), .BAout(w_BAout), .alu_control(w_alu_control), .run(w_run),
    .illegal_op(w_illegal_op), .instr_count(w_instr_count), .dbg_state(w_dbg_state)
  );

  always #5 clk = ~clk;

  function automatic logic [25:0] obs();
    return {Pout, Pen, IncPC, MARen, MDRen, MDROut, IRen, Yen, ZLOen, ZLOout, Cout,
            Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, alu_control, illegal_op, run};
  endfunction

  function automatic bit is_rfmt(input logic [4:0] op);
    return (op == O_ADD) || (op == O_SUB) || (op == O_AND) || (op == O_OR);
  endfunction

  function automatic int instr_len(input logic [4:0] op);
    if (is_rfmt(op) || op == O_LDI || op == O_ADDI) return 6;
    if (op == O_LD || op == O_ST) return 8;
    return 4;
  endfunction

  // Expected outputs in cycle k of an instruction (k = 0 is T0).
  function automatic logic [25:0] exp_vec(input logic [4:0] op, input int k);
    logic [25:0] v;
    bit known;
    known = is_rfmt(op) || op == O_LD || op == O_ST || op == O_LDI || op == O_ADDI ||
            op == O_NOP || op == O_HALT;
    v = '0;
    v[B_RUN] = 1'b1;
    case (k)
      0: begin v[B_POUT] = 1; v[B_MAR] = 1; v[B_INC] = 1; v[B_ZEN] = 1; end
      1: begin v[B_ZOUT] = 1; v[B_PEN] = 1; v[B_READ] = 1; v[B_MDREN] = 1; end
      2: begin v[B_MDROUT] = 1; v[B_IREN] = 1; end
      3: begin
        if (is_rfmt(op) || op == O_ADDI) begin v[B_GRB] = 1; v[B_ROUT] = 1; v[B_YEN] = 1; end
        else if (op == O_LDI || op == O_LD || op == O_ST) begin
          v[B_GRB] = 1; v[B_BA] = 1; v[B_YEN] = 1;
        end
        if (!known) v[B_ILL] = 1;
      end
      4: begin
        v[B_ZEN] = 1;
        if (is_rfmt(op)) begin v[B_GRC] = 1; v[B_ROUT] = 1; v[6:2] = op; end
        else begin v[B_COUT] = 1; v[6:2] = 5'b00011; end
      end
      5: begin
        v[B_ZOUT] = 1;
        if (op == O_LD || op == O_ST) v[B_MAR] = 1;
        else begin v[B_GRA] = 1; v[B_RIN] = 1; end
      end
      6: begin
        v[B_MDREN] = 1;
        if (op == O_LD) v[B_READ] = 1;
        else begin v[B_GRA] = 1; v[B_ROUT] = 1; end
      end
      7: begin
        if (op == O_LD) begin v[B_MDROUT] = 1; v[B_GRA] = 1; v[B_RIN] = 1; end
        else v[B_WRITE] = 1;
      end
      default: ;
    endcase
    return v;
  endfunction

  // Driver: called at a falling edge with the DUT in T0; returns at the falling
  // edge after the instruction's boundary, reporting any per-cycle mismatch.
  task automatic run_instr(input logic [31:0] ir_val, input int stop_k,
                           output int bad, output int bad_k,
                           output logic [25:0] bad_obs, output logic [25:0] bad_exp);
    logic [4:0] op;
    logic [25:0] o, e;
    int len;
    op = ir_val[31:27];
    len = instr_len(op);
    ir = ir_val;
    stop = 1'b0;
    bad = 0; bad_k = -1; bad_obs = '0; bad_exp = '0;
    for (int k = 0; k < len; k++) begin
      if (k > 0) @(negedge clk);
      o = obs();
      e = exp_vec(op, k);
      if (o !== e && bad == 0) begin bad_k = k; bad_obs = o; bad_exp = e; end
      if (o !== e) bad++;
      if (k == stop_k) stop = 1'b1;
    end
    @(negedge clk);
    if (op != O_HALT) model_count = model_count + 16'd1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b0;
    stop = 1'b0;
    model_count = '0;
    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [25:0] t0v;
    @(negedge clk);
    clr = 1'b0;
    ir = $urandom;
    #2;
    checks++;
    if (obs() !== 26'd0) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", obs(), 26'd0);
    end
    checks++;
    if (instr_count !== 16'd0 || w_instr_count !== 3'd0) begin
      errors++; $display("FAIL reset_count: got %h/%h expected 0", instr_count, w_instr_count);
    end
    @(negedge clk);
    clr = 1'b1;
    model_count = '0;
    @(negedge clk);
    t0v = exp_vec(O_NOP, 0);
    checks++;
    if (obs() !== t0v) begin
      errors++; $display("FAIL reset_release_t0: got %h expected %h", obs(), t0v);
    end
  endtask

  task automatic exec_and_check(input string name, input logic [31:0] ir_val);
    int bad, bad_k;
    logic [25:0] bo, be, t0v;
    run_instr(ir_val, -1, bad, bad_k, bo, be);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL %s_cycles: %0d bad cycles, first k=%0d got %h expected %h",
               name, bad, bad_k, bo, be);
    end
    checks++;
    if (instr_count !== model_count || w_instr_count !== model_count[2:0]) begin
      errors++;
      $display("FAIL %s_count: got %h/%h expected %h", name, instr_count, w_instr_count,
               model_count);
    end
    t0v = exp_vec(O_NOP, 0);
    checks++;
    if (obs() !== t0v) begin
      errors++; $display("FAIL %s_next_t0: got %h expected %h", name, obs(), t0v);
    end
  endtask

  task automatic test_ldi();
    exec_and_check("ldi", 32'h09900065);
    exec_and_check("addi", {O_ADDI, 27'h1900065});
  endtask

  task automatic test_rformat();
    exec_and_check("add", 32'h1A920000);
    exec_and_check("sub", 32'h22920000);
    exec_and_check("and", {O_AND, 27'h0920000});
    exec_and_check("or", {O_OR, 27'h0920000});
  endtask

  task automatic test_mem();
    exec_and_check("ld", 32'h00800054);
    exec_and_check("st", 32'h10800054);
  endtask

  task automatic test_nop_illegal();
    exec_and_check("nop", {O_NOP, 27'h0});
    exec_and_check("illegal", {5'b00101, 27'h1234567});
    exec_and_check("illegal2", {5'b11111, 27'h7654321});
  endtask

  task automatic test_random();
    logic [4:0] ops [12];
    logic [31:0] v;
    ops = '{O_LD, O_LDI, O_ST, O_ADD, O_SUB, O_AND, O_OR, O_ADDI, O_NOP,
            5'b00110, 5'b10000, 5'b11100};
    for (int i = 0; i < 24; i++) begin
      v = {ops[$urandom_range(0, 11)], 27'($urandom)};
      exec_and_check("random", v);
    end
  endtask

  task automatic test_stop();
    int bad, bad_k;
    logic [25:0] bo, be;
    do_reset();
    run_instr(32'h1A920000, 4, bad, bad_k, bo, be);
    stop = 1'b0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL stop_add_cycles: %0d bad, k=%0d got %h expected %h", bad, bad_k, bo, be);
    end
    checks++;
    if (instr_count !== model_count) begin
      errors++; $display("FAIL stop_count: got %h expected %h", instr_count, model_count);
    end
    for (int i = 0; i < 6; i++) begin
      ir = $urandom;
      #1;
      checks++;
      if (obs() !== 26'd0 || instr_count !== model_count) begin
        errors++;
        $display("FAIL stop_halted: got %h count %h expected 0 count %h", obs(), instr_count,
                 model_count);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_halt();
    int bad, bad_k;
    logic [25:0] bo, be;
    do_reset();
    exec_and_check("pre_halt", 32'h09900065);
    run_instr(32'hD0000000, -1, bad, bad_k, bo, be);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL halt_cycles: %0d bad, k=%0d got %h expected %h", bad, bad_k, bo, be);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs() !== 26'd0 || instr_count !== 16'd1) begin
        errors++;
        $display("FAIL halt_state: got %h count %h expected 0 count 1", obs(), instr_count);
      end
      @(negedge clk);
      ir = $urandom;
    end
  endtask

  task automatic test_reset_mid();
    logic [25:0] t0v;
    int wrote;
    do_reset();
    exec_and_check("pre_st", 32'h1A920000);
    ir = 32'h10800054;
    for (int k = 0; k < 6; k++) @(negedge clk);
    // DUT is in T6 of st here; pull reset mid-cycle.
    #2 clr = 1'b0;
    model_count = '0;
    #1;
    checks++;
    if (obs() !== 26'd0 || instr_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset_abort: got %h count %h expected 0 count 0", obs(), instr_count);
    end
    wrote = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (Write !== 1'b0) wrote++;
    end
    clr = 1'b1;
    @(negedge clk);
    if (Write !== 1'b0) wrote++;
    checks++;
    if (wrote !== 0) begin
      errors++; $display("FAIL mid_reset_write: got %0d write cycles expected 0", wrote);
    end
    t0v = exp_vec(O_NOP, 0);
    checks++;
    if (obs() !== t0v || instr_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset_restart: got %h count %h expected %h count 0", obs(),
               instr_count, t0v);
    end
    exec_and_check("post_reset_nop", {O_NOP, 27'h0});
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 7; i++) exec_and_check("wrap_nop", {O_NOP, 27'($urandom)});
    checks++;
    if (w_instr_count !== 3'd7) begin
      errors++; $display("FAIL wrap_top: got %h expected 7", w_instr_count);
    end
    exec_and_check("wrap_last", 32'h09900065);
    checks++;
    if (w_instr_count !== 3'd0 || instr_count !== 16'd8) begin
      errors++;
      $display("FAIL wrap_zero: got %h/%h expected 0/8", w_instr_count, instr_count);
    end
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_rformat();
    test_mem();
    test_nop_illegal();
    test_random();
    test_stop();
    test_halt();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
